fp16_dot_seq: RTL and testbench
===============================

Name: fp16_dot_seq

Overview:
Sequencer that drives a single fp16MAC instance to compute dot products of length len over a valid/ready operand stream. It clears the MAC, feeds one operand pair per accepted beat and drains the MAC pipeline. It then captures the accumulator into a held result with a valid/ready output handshake. It sits between the operand source (buffer or DMA) and the fp16MAC datapath, and owns the MAC's clear (RESETn) pin.

Parameters:
MAC_LAT, 2, cycles from operands presented on mac_a/mac_b to the updated value visible on mac_acc
CLR_CYC, 1, cycles mac_resetn is held low to clear the accumulator
LEN_W, 8, width of the vector length and element counter

Ports:
CLK  in  1  clock, rising edge
RESET  in  1  synchronous reset, active-high
start  in  1  begin a dot product; accepted only when start_ready=1
len  in  LEN_W  element count, sampled on accepted start
start_ready  out  1  high only in IDLE
abort  in  1  synchronous abort, returns to IDLE, no result
in_valid  in  1  operand pair valid
in_ready  out  1  high only in FEED
in_a  in  16  fp16 operand a
in_b  in  16  fp16 operand b
out_valid  out  1  result valid
out_ready  in  1  result consumed
result  out  16  captured fp16 dot product
result_exc  out  1  result exponent == 5'h1F (inf/NaN)
mac_a  out  16  to fp16MAC a
mac_b  out  16  to fp16MAC b
mac_resetn  out  1  to fp16MAC RESETn, active-low clear
mac_acc  in  16  from fp16MAC acc
busy  out  1  state != IDLE

Behaviour:
- Reset values: state IDLE, mac_a=mac_b=16'h0000, mac_resetn=0 while RESET is high, then 1 in IDLE; out_valid=0, result=0, result_exc=0, in_ready=0, busy=0, counter=0.
- Outputs mac_a, mac_b, mac_resetn, result, result_exc and out_valid are registered. in_ready and start_ready are decoded from the state.
- When no beat is issued, mac_a and mac_b are +0 (16'h0000), so the MAC accumulator is unchanged.
- IDLE: on start, latch len and clear the counter. If len==0, go to DONE with result=0 and result_exc=0, and do not clear or feed the MAC. Otherwise go to CLEAR.
- CLEAR: mac_resetn=0 for CLR_CYC cycles, then go to FEED with mac_resetn=1.
- FEED: in_ready=1. Each cycle with in_valid&in_ready, register mac_a=in_a and mac_b=in_b for exactly one cycle and increment the counter. Cycles without a beat drive zeros. When counter reaches len-1 on an accepted beat, go to DRAIN.
- DRAIN: drive zero operands and wait MAC_LAT cycles, counted from the last beat's mac_a cycle. Then capture result=mac_acc and result_exc=(mac_acc[14:10]==5'h1F), set out_valid=1 and go to DONE.
- DONE: hold result, result_exc and out_valid stable until out_ready=1. On that edge clear out_valid and go to IDLE. Back-to-back: start is accepted no earlier than the cycle after return to IDLE.
- start outside IDLE is ignored and not queued.
- abort in any non-IDLE state: next state IDLE, out_valid=0, operands zero. abort in IDLE has no effect. If abort and start arrive in the same cycle in IDLE, start wins, since abort is ignored in IDLE. If abort and out_ready arrive in the same cycle in DONE, abort wins and the result is discarded. The MAC is not cleared on abort; the next run's CLEAR handles it.
- RESET mid-operation: same as abort, plus all registered outputs return to their reset values.
- Counter: LEN_W bits, no wrap beyond len; maximum len = 2^LEN_W-1.
- No arithmetic is done here. Rounding and exception values are those produced by fp16MAC.

Decomposition:
- Shared package fp16_pkg holds:
  - state encoding: IDLE, CLEAR, FEED, DRAIN, DONE
  - FP16_ZERO = 16'h0000
  - FP16_EXP_MAX = 5'h1F
  - FP16 field slices: sign [15], exp [14:10], man [9:0]
- No sub-module is needed; fp16MAC is instantiated beside this block at the level above.
- An optional generic delay counter can be shared between CLEAR and DRAIN.

Test Plan:
- len=4, four beats of 3C00×3C00 with in_valid held high -> result=4400, result_exc=0, out_valid exactly MAC_LAT+1 cycles after the last beat.
- len=2, beats (4000,4200) then (3C00,3C00) with 3 idle cycles of in_valid=0 between them -> result=4700, and mac_a/mac_b=0000 during the gap.
- len=0 start -> out_valid=1 within 2 cycles, result=0000, mac_resetn never low, in_ready never high.
- Run len=1 (3C00,4000) -> result=4000. Hold out_ready=0 for 5 cycles and pulse start -> result stable and start ignored. Then release, start len=1 (3C00,3C00) -> result=3C00, confirming CLEAR wiped the prior accumulation.
- len=3, abort after 1 beat -> IDLE the next cycle, out_valid never asserts, start_ready=1.
- len=1, beat (7BFF,7BFF) -> result=7C00, result_exc=1. Then assert RESET in FEED of a following run -> all outputs return to reset values.

Source files
------------

// File: rtl/fp16_pkg.sv
// rtl/fp16_pkg.sv - shared fp16 field layout, constants and sequencer state encoding
package fp16_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_CLEAR = 3'd1;
  localparam logic [2:0] ST_FEED  = 3'd2;
  localparam logic [2:0] ST_DRAIN = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  localparam logic [15:0] FP16_ZERO    = 16'h0000;
  localparam logic [4:0]  FP16_EXP_MAX = 5'h1F;

  typedef struct packed {
    logic       sign;
    logic [4:0] exp;
    logic [9:0] man;
  } fp16_t;

  // All-ones exponent marks inf or NaN; the mantissa tells them apart.
  function automatic logic fp16_is_exc(input fp16_t v);
    return v.exp == FP16_EXP_MAX;
  endfunction

endpackage

// File: rtl/fp16_dot_seq.sv
// rtl/fp16_dot_seq.sv - sequencer driving one fp16MAC through clear, feed, drain and result hold
module fp16_dot_seq
  import fp16_pkg::*;
#(
  parameter int MAC_LAT = 2,
  parameter int CLR_CYC = 1,
  parameter int LEN_W   = 8
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  output logic             start_ready,
  input  logic             abort,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_a,
  input  logic [15:0]      in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      result,
  output logic             result_exc,
  output logic [15:0]      mac_a,
  output logic [15:0]      mac_b,
  output logic             mac_resetn,
  input  logic [15:0]      mac_acc,
  output logic             busy
);

  localparam int DLY_W = 8;

  logic [2:0]       state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [DLY_W-1:0] dly_q, dly_d;
  logic [15:0]      mac_a_q, mac_a_d;
  logic [15:0]      mac_b_q, mac_b_d;
  logic             mac_resetn_q, mac_resetn_d;
  logic [15:0]      result_q, result_d;
  logic             exc_q, exc_d;
  logic             out_valid_q, out_valid_d;
  fp16_t            acc_f;

  assign acc_f = mac_acc;

  always_comb begin
    state_d      = state_q;
    len_d        = len_q;
    cnt_d        = cnt_q;
    dly_d        = dly_q;
    mac_a_d      = FP16_ZERO;
    mac_b_d      = FP16_ZERO;
    mac_resetn_d = 1'b1;
    result_d     = result_q;
    exc_d        = exc_q;
    out_valid_d  = out_valid_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          len_d = len;
          cnt_d = '0;
          dly_d = '0;
          if (len == '0) begin
            // Empty vector: report +0 without touching the MAC.
            state_d     = ST_DONE;
            result_d    = FP16_ZERO;
            exc_d       = 1'b0;
            out_valid_d = 1'b1;
          end else begin
            state_d      = ST_CLEAR;
            mac_resetn_d = 1'b0;
          end
        end
      end
      ST_CLEAR: begin
        if (dly_q == DLY_W'(CLR_CYC - 1)) begin
          state_d = ST_FEED;
          dly_d   = '0;
        end else begin
          dly_d        = dly_q + 1'b1;
          mac_resetn_d = 1'b0;
        end
      end
      ST_FEED: begin
        if (in_valid) begin
          mac_a_d = in_a;
          mac_b_d = in_b;
          cnt_d   = cnt_q + 1'b1;
          if (cnt_q == len_q - 1'b1) begin
            state_d = ST_DRAIN;
            dly_d   = '0;
          end
        end
      end
      ST_DRAIN: begin
        // dly_q is 0 in the cycle the last operands sit on mac_a/mac_b.
        if (dly_q == DLY_W'(MAC_LAT)) begin
          result_d    = mac_acc;
          exc_d       = fp16_is_exc(acc_f);
          out_valid_d = 1'b1;
          state_d     = ST_DONE;
        end else begin
          dly_d = dly_q + 1'b1;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Abort leaves the accumulator dirty; the next CLEAR wipes it.
    if (abort && (state_q != ST_IDLE)) begin
      state_d      = ST_IDLE;
      out_valid_d  = 1'b0;
      mac_a_d      = FP16_ZERO;
      mac_b_d      = FP16_ZERO;
      mac_resetn_d = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q      <= ST_IDLE;
      len_q        <= '0;
      cnt_q        <= '0;
      dly_q        <= '0;
      mac_a_q      <= FP16_ZERO;
      mac_b_q      <= FP16_ZERO;
      mac_resetn_q <= 1'b0;
      result_q     <= FP16_ZERO;
      exc_q        <= 1'b0;
      out_valid_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      cnt_q        <= cnt_d;
      dly_q        <= dly_d;
      mac_a_q      <= mac_a_d;
      mac_b_q      <= mac_b_d;
      mac_resetn_q <= mac_resetn_d;
      result_q     <= result_d;
      exc_q        <= exc_d;
      out_valid_q  <= out_valid_d;
    end
  end

  assign start_ready = (state_q == ST_IDLE);
  assign in_ready    = (state_q == ST_FEED);
  assign busy        = (state_q != ST_IDLE);
  assign mac_a       = mac_a_q;
  assign mac_b       = mac_b_q;
  assign mac_resetn  = mac_resetn_q;
  assign result      = result_q;
  assign result_exc  = exc_q;
  assign out_valid   = out_valid_q;

endmodule

// File: tb/tb_fp16_dot_seq.sv
// tb/tb_fp16_dot_seq.sv - scoreboard bench for fp16_dot_seq with a behavioural two-stage fp16 MAC
module tb_fp16_dot_seq;

  localparam int MAC_LAT = 2;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  len = 8'd0;
  logic        start_ready;
  logic        abort = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_a = 16'h0;
  logic [15:0] in_b = 16'h0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] result;
  logic        result_exc;
  logic [15:0] mac_a;
  logic [15:0] mac_b;
  logic        mac_resetn;
  logic [15:0] mac_acc;
  logic        busy;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [15:0] res;
    logic        exc;
  } exp_t;
  exp_t exp_q[$];

  always #5 CLK = ~CLK;

  fp16_dot_seq #(.MAC_LAT(MAC_LAT), .CLR_CYC(1), .LEN_W(8)) dut (
    .CLK(CLK), .RESET(RESET), .start(start), .len(len), .start_ready(start_ready),
    .abort(abort), .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready), .result(result), .result_exc(result_exc),
    .mac_a(mac_a), .mac_b(mac_b), .mac_resetn(mac_resetn), .mac_acc(mac_acc), .busy(busy)
  );

  function automatic real h2r(input logic [15:0] h);
    int  e;
    real m;
    e = int'(h[14:10]);
    if (e == 0) return 0.0;
    if (e == 31) m = 1.0e30;
    else m = (1.0 + real'(h[9:0]) / 1024.0) * (2.0 ** (e - 15));
    return h[15] ? -m : m;
  endfunction

  function automatic logic [15:0] r2h(input real r);
    logic s;
    real  a;
    int   e;
    int   man;
    s = (r < 0.0);
    a = s ? -r : r;
    if (a == 0.0) return {s, 15'h0};
    e = 15;
    while (a >= 2.0 && e < 200) begin a = a / 2.0; e++; end
    while (a < 1.0 && e > -200) begin a = a * 2.0; e--; end
    if (e >= 31) return {s, 5'h1F, 10'h0};
    if (e <= 0) return {s, 15'h0};
    man = int'((a - 1.0) * 1024.0);
    if (man >= 1024) begin man = 0; e++; end
    if (e >= 31) return {s, 5'h1F, 10'h0};
    return {s, 5'(e), 10'(man)};
  endfunction

  // Stand-in fp16MAC: product stage then accumulate stage.
  logic [15:0] prod_q = 16'h0;
  logic [15:0] acc_q = 16'h0;
  always @(posedge CLK) begin
    if (!mac_resetn) begin
      prod_q <= 16'h0;
      acc_q  <= 16'h0;
    end else begin
      prod_q <= r2h(h2r(mac_a) * h2r(mac_b));
      acc_q  <= r2h(h2r(acc_q) + h2r(prod_q));
    end
  end
  assign mac_acc = acc_q;

  always @(negedge CLK) begin
    if (!RESET && !abort && out_valid && out_ready) begin
      exp_t e;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_result: got %h with no expected entry", result);
      end else begin
        e = exp_q.pop_front();
        if (result !== e.res || result_exc !== e.exc) begin
          errors++;
          $display("FAIL result: got %h exc %b, expected %h exc %b", result, result_exc, e.res, e.exc);
        end
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_start(input logic [7:0] l);
    int n = 0;
    while (!start_ready && n < 50) begin tick(); n++; end
    checks++;
    if (!start_ready) begin errors++; $display("FAIL start_wait: start_ready %b expected 1", start_ready); end
    start = 1'b1;
    len   = l;
    tick();
    start = 1'b0;
  endtask

  task automatic beat(input logic [15:0] a, input logic [15:0] b);
    int n = 0;
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
    while (!in_ready && n < 50) begin tick(); n++; end
    checks++;
    if (!in_ready) begin errors++; $display("FAIL beat_wait: in_ready %b expected 1", in_ready); end
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!out_valid && n < 50) begin tick(); n++; end
    checks++;
    if (!out_valid) begin errors++; $display("FAIL valid_wait: out_valid %b expected 1", out_valid); end
  endtask

  task automatic check_reset_values(input string tag);
    checks++;
    if ({out_valid, result, result_exc, mac_a, mac_b, mac_resetn, in_ready, busy, start_ready}
        !== {1'b0, 16'h0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL %s: ov %b res %h exc %b a %h b %h rn %b ir %b busy %b sr %b, expected 0 0000 0 0000 0000 0 0 0 1",
               tag, out_valid, result, result_exc, mac_a, mac_b, mac_resetn, in_ready, busy, start_ready);
    end
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    repeat (3) tick();
    check_reset_values("reset_state");
    RESET = 1'b0;
    repeat (2) tick();
    checks++;
    if (mac_resetn !== 1'b1) begin errors++; $display("FAIL idle_mac_resetn: got %b expected 1", mac_resetn); end
  endtask

  task automatic test_len4_stream();
    int n;
    exp_q.push_back('{16'h4400, 1'b0});
    do_start(8'd4);
    for (int i = 0; i < 4; i++) beat(16'h3C00, 16'h3C00);
    wait_valid(n);
    checks++;
    if (n != MAC_LAT + 1) begin errors++; $display("FAIL len4_latency: got %0d cycles expected %0d", n, MAC_LAT + 1); end
    tick();
  endtask

  task automatic test_gap();
    int n;
    exp_q.push_back('{16'h4700, 1'b0});
    do_start(8'd2);
    beat(16'h4000, 16'h4200);
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (mac_a !== 16'h0 || mac_b !== 16'h0) begin
        errors++;
        $display("FAIL gap_operands: got %h %h expected 0000 0000", mac_a, mac_b);
      end
    end
    beat(16'h3C00, 16'h3C00);
    wait_valid(n);
    tick();
  endtask

  task automatic test_len0();
    exp_q.push_back('{16'h0000, 1'b0});
    checks++;
    if (mac_resetn !== 1'b1 || in_ready !== 1'b0) begin
      errors++; $display("FAIL len0_pre: rn %b ir %b expected 1 0", mac_resetn, in_ready);
    end
    do_start(8'd0);
    checks++;
    if (out_valid !== 1'b1 || mac_resetn !== 1'b1 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL len0: ov %b rn %b ir %b expected 1 1 0", out_valid, mac_resetn, in_ready);
    end
    tick();
  endtask

  task automatic test_hold_and_clear();
    int n;
    out_ready = 1'b0;
    exp_q.push_back('{16'h4000, 1'b0});
    do_start(8'd1);
    beat(16'h3C00, 16'h4000);
    wait_valid(n);
    for (int i = 0; i < 5; i++) begin
      start = (i == 2);
      len   = 8'd1;
      tick();
      checks++;
      if (out_valid !== 1'b1 || result !== 16'h4000 || start_ready !== 1'b0) begin
        errors++;
        $display("FAIL hold: ov %b res %h sr %b expected 1 4000 0", out_valid, result, start_ready);
      end
    end
    start = 1'b0;
    out_ready = 1'b1;
    tick();
    checks++;
    if (out_valid !== 1'b0 || start_ready !== 1'b1) begin
      errors++; $display("FAIL hold_release: ov %b sr %b expected 0 1", out_valid, start_ready);
    end
    exp_q.push_back('{16'h3C00, 1'b0});
    do_start(8'd1);
    beat(16'h3C00, 16'h3C00);
    wait_valid(n);
    tick();
  endtask

  task automatic test_abort();
    int seen = 0;
    do_start(8'd3);
    beat(16'h3C00, 16'h3C00);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checks++;
    if (start_ready !== 1'b1 || busy !== 1'b0 || in_ready !== 1'b0) begin
      errors++; $display("FAIL abort_idle: sr %b busy %b ir %b expected 1 0 0", start_ready, busy, in_ready);
    end
    for (int i = 0; i < 8; i++) begin
      if (out_valid) seen++;
      tick();
    end
    checks++;
    if (seen != 0) begin errors++; $display("FAIL abort_no_result: out_valid seen %0d cycles expected 0", seen); end
  endtask

  task automatic test_exc_then_reset();
    int n;
    exp_q.push_back('{16'h7C00, 1'b1});
    do_start(8'd1);
    beat(16'h7BFF, 16'h7BFF);
    wait_valid(n);
    tick();
    do_start(8'd2);
    beat(16'h3C00, 16'h3C00);
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL feed_state: in_ready %b expected 1", in_ready); end
    RESET = 1'b1;
    tick();
    check_reset_values("reset_mid_feed");
    RESET = 1'b0;
    repeat (2) tick();
  endtask

  initial begin
    test_reset();
    test_len4_stream();
    test_gap();
    test_len0();
    test_hold_and_clear();
    test_abort();
    test_exc_then_reset();
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL scoreboard_drain: %0d results outstanding expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
